// File: rtl/unified_mem_arbiter_if.sv
// Bundle of the core-side fetch/data handshakes and the unified memory port.
// The arbiter uses the master modport; the core/memory environment uses slave.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic                  if_request;
    logic [ADDR_W-1:0]     if_address;
    logic                  if_valid;
    logic [DATA_W-1:0]     if_data_out;

    logic                  dm_request;
    logic                  dm_we_re;
    logic [DATA_W/8-1:0]   dm_mask;
    logic [ADDR_W-1:0]     dm_address;
    logic [DATA_W-1:0]     dm_data_in;
    logic                  dm_valid;
    logic [DATA_W-1:0]     dm_data_out;

    logic                  mem_request;
    logic                  mem_we_re;
    logic [DATA_W/8-1:0]   mem_mask;
    logic [ADDR_W-1:0]     mem_address;
    logic [DATA_W-1:0]     mem_data_in;
    logic                  mem_valid;
    logic [DATA_W-1:0]     mem_data_out;

    logic                  grant_dm;

    modport master (
        input  if_request, if_address,
        input  dm_request, dm_we_re, dm_mask, dm_address, dm_data_in,
        input  mem_valid, mem_data_out,
        output if_valid, if_data_out, dm_valid, dm_data_out,
        output mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
        output grant_dm
    );

    modport slave (
        output if_request, if_address,
        output dm_request, dm_we_re, dm_mask, dm_address, dm_data_in,
        output mem_valid, mem_data_out,
        input  if_valid, if_data_out, dm_valid, dm_data_out,
        input  mem_request, mem_we_re, mem_mask, mem_address, mem_data_in,
        input  grant_dm
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one word-addressed memory port between instruction fetch and data
// access, one transaction at a time, alternating priority on conflicts.
module unified_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    unified_mem_arbiter_if.master    bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_IF = 2'd1,
        SERVE_DM = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic                last_dm_q,     last_dm_d;
    logic                mem_request_q, mem_request_d;
    logic                mem_we_re_q,   mem_we_re_d;
    logic [MASK_W-1:0]   mem_mask_q,    mem_mask_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;

    logic                grant_dm_now;

    // Data side wins a conflict unless it owned the previous transaction.
    assign grant_dm_now = bus.dm_request && (!bus.if_request || !last_dm_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_dm_q     <= 1'b0;
            mem_request_q <= 1'b0;
            mem_we_re_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
        end else begin
            state_q       <= state_d;
            last_dm_q     <= last_dm_d;
            mem_request_q <= mem_request_d;
            mem_we_re_q   <= mem_we_re_d;
            mem_mask_q    <= mem_mask_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_dm_d       = last_dm_q;
        mem_request_d   = mem_request_q;
        mem_we_re_d     = mem_we_re_q;
        mem_mask_d      = mem_mask_q;
        mem_address_d   = mem_address_q;
        mem_data_in_d   = mem_data_in_q;
        bus.if_valid    = 1'b0;
        bus.if_data_out = '0;
        bus.dm_valid    = 1'b0;
        bus.dm_data_out = '0;

        unique case (state_q)
            IDLE: begin
                if (grant_dm_now) begin
                    state_d       = SERVE_DM;
                    mem_request_d = 1'b1;
                    mem_we_re_d   = bus.dm_we_re;
                    mem_mask_d    = bus.dm_mask;
                    mem_address_d = bus.dm_address;
                    mem_data_in_d = bus.dm_data_in;
                end else if (bus.if_request) begin
                    // Fetch grants leave the write-data register untouched.
                    state_d       = SERVE_IF;
                    mem_request_d = 1'b1;
                    mem_we_re_d   = 1'b0;
                    mem_mask_d    = '1;
                    mem_address_d = bus.if_address;
                end
            end
            SERVE_IF: begin
                if (bus.mem_valid) begin
                    bus.if_valid    = 1'b1;
                    bus.if_data_out = bus.mem_data_out;
                    mem_request_d   = 1'b0;
                    last_dm_d       = 1'b0;
                    state_d         = IDLE;
                end
            end
            SERVE_DM: begin
                if (bus.mem_valid) begin
                    bus.dm_valid    = 1'b1;
                    bus.dm_data_out = bus.mem_data_out;
                    mem_request_d   = 1'b0;
                    last_dm_d       = 1'b1;
                    state_d         = IDLE;
                end
            end
            default: begin
                state_d       = IDLE;
                mem_request_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_request = mem_request_q;
    assign bus.mem_we_re   = mem_we_re_q;
    assign bus.mem_mask    = mem_mask_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data_in = mem_data_in_q;
    assign bus.grant_dm    = (state_q == SERVE_DM);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: transaction-level owner model checked
// every cycle, plus literal expectations for each scenario.
module tb_unified_mem_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the memory (0 none, 1 fetch, 2 data) and the captured request.
    int          owner = 0;
    bit          last_was_dm = 0;
    logic        e_req = 0, e_we = 0;
    logic [3:0]  e_mask = '0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_din = '0;
    bit          model_on = 0;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; last_was_dm = 0;
            e_req = 0; e_we = 0; e_mask = '0; e_addr = '0; e_din = '0;
            model_on = 1;
        end else if (owner == 0) begin
            if (bus.dm_request && !(bus.if_request && last_was_dm)) begin
                owner = 2; e_req = 1; e_we = bus.dm_we_re; e_mask = bus.dm_mask;
                e_addr = bus.dm_address; e_din = bus.dm_data_in;
            end else if (bus.if_request) begin
                owner = 1; e_req = 1; e_we = 0; e_mask = 4'hF; e_addr = bus.if_address;
            end
        end else if (bus.mem_valid) begin
            last_was_dm = (owner == 2);
            owner = 0; e_req = 0;
        end
    end

    int   n_if_v = 0, n_dm_v = 0;
    bit   prev_req = 0;
    bit   grant_log[$];

    always @(negedge clk) begin
        if (model_on) begin
            bit xif, xdm;
            xif = (owner == 1) && bus.mem_valid;
            xdm = (owner == 2) && bus.mem_valid;
            check("if_valid",    {31'b0, bus.if_valid},    {31'b0, xif});
            check("if_data_out", bus.if_data_out,          xif ? bus.mem_data_out : 32'h0);
            check("dm_valid",    {31'b0, bus.dm_valid},    {31'b0, xdm});
            check("dm_data_out", bus.dm_data_out,          xdm ? bus.mem_data_out : 32'h0);
            check("mem_request", {31'b0, bus.mem_request}, {31'b0, e_req});
            check("mem_we_re",   {31'b0, bus.mem_we_re},   {31'b0, e_we});
            check("mem_mask",    {28'b0, bus.mem_mask},    {28'b0, e_mask});
            check("mem_address", {24'b0, bus.mem_address}, {24'b0, e_addr});
            check("mem_data_in", bus.mem_data_in,          e_din);
            check("grant_dm",    {31'b0, bus.grant_dm},    {31'b0, owner == 2});
            if (bus.if_valid) n_if_v++;
            if (bus.dm_valid) n_dm_v++;
            if (bus.mem_request && !prev_req) grant_log.push_back(bus.grant_dm);
            prev_req = bus.mem_request;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int if0, dm0, g0;
        rst = 1;
        bus.if_request = 0; bus.if_address = '0;
        bus.dm_request = 0; bus.dm_we_re = 0; bus.dm_mask = '0;
        bus.dm_address = '0; bus.dm_data_in = '0;
        bus.mem_valid = 0; bus.mem_data_out = '0;
        step(); step();
        #1;
        check("rst mem_request", {31'b0, bus.mem_request}, 32'h0);
        check("rst grant_dm",    {31'b0, bus.grant_dm},    32'h0);
        rst = 0;

        // Single fetch, zero-wait
        bus.if_request = 1; bus.if_address = 8'h04;
        step();
        bus.mem_valid = 1; bus.mem_data_out = 32'h00500093;
        #1;
        check("fetch mem_address", {24'b0, bus.mem_address}, 32'h04);
        check("fetch mem_we_re",   {31'b0, bus.mem_we_re},   32'h0);
        check("fetch mem_mask",    {28'b0, bus.mem_mask},    32'hF);
        check("fetch if_valid",    {31'b0, bus.if_valid},    32'h1);
        check("fetch if_data_out", bus.if_data_out,          32'h00500093);
        step();
        bus.if_request = 0; bus.mem_valid = 0;
        #1;
        check("fetch req drop", {31'b0, bus.mem_request}, 32'h0);

        // Store with three wait cycles
        if0 = n_if_v; dm0 = n_dm_v;
        bus.dm_request = 1; bus.dm_we_re = 1; bus.dm_mask = 4'b0011;
        bus.dm_address = 8'h10; bus.dm_data_in = 32'hDEADBEEF;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("store held addr", {24'b0, bus.mem_address}, 32'h10);
            check("store held data", bus.mem_data_in,          32'hDEADBEEF);
            step();
        end
        bus.mem_valid = 1; bus.mem_data_out = 32'h0;
        #1;
        check("store dm_valid", {31'b0, bus.dm_valid},  32'h1);
        check("store mem_we_re", {31'b0, bus.mem_we_re}, 32'h1);
        check("store mem_mask", {28'b0, bus.mem_mask},  32'h3);
        step();
        bus.dm_request = 0; bus.mem_valid = 0;
        step();
        check("store dm pulses", n_dm_v - dm0, 1);
        check("store no if",     n_if_v - if0, 0);

        // Stray valid while idle
        bus.mem_valid = 1; bus.mem_data_out = 32'h12345678;
        #1;
        check("stray if_valid", {31'b0, bus.if_valid}, 32'h0);
        check("stray dm_valid", {31'b0, bus.dm_valid}, 32'h0);
        step();
        bus.mem_valid = 0;
        #1;
        check("stray idle req", {31'b0, bus.mem_request}, 32'h0);
        check("stray grant_dm", {31'b0, bus.grant_dm},    32'h0);

        // Dropped data request, fetch pending behind it
        bus.dm_request = 1; bus.dm_we_re = 0; bus.dm_mask = 4'hF;
        bus.dm_address = 8'h22; bus.dm_data_in = 32'h0;
        step();
        bus.dm_request = 0; bus.if_request = 1; bus.if_address = 8'h08;
        step(); step();
        bus.mem_valid = 1; bus.mem_data_out = 32'hCAFEF00D;
        #1;
        check("drop dm_valid",    {31'b0, bus.dm_valid}, 32'h1);
        check("drop dm_data_out", bus.dm_data_out,       32'hCAFEF00D);
        step();
        bus.mem_valid = 0;
        step();
        check("drop next grant if", {31'b0, bus.grant_dm},    32'h0);
        check("drop next req",      {31'b0, bus.mem_request}, 32'h1);
        check("drop next addr",     {24'b0, bus.mem_address}, 32'h08);
        bus.mem_valid = 1; bus.mem_data_out = 32'h0000AAAA;
        step();
        bus.if_request = 0; bus.mem_valid = 0;
        step();

        // Reset while serving a fetch
        if0 = n_if_v;
        bus.if_request = 1; bus.if_address = 8'h20;
        step();
        rst = 1; bus.if_request = 0;
        step();
        rst = 0; bus.mem_valid = 1; bus.mem_data_out = 32'h55555555;
        #1;
        check("rstmid mem_request", {31'b0, bus.mem_request}, 32'h0);
        check("rstmid mem_address", {24'b0, bus.mem_address}, 32'h0);
        check("rstmid if_valid",    {31'b0, bus.if_valid},    32'h0);
        check("rstmid grant_dm",    {31'b0, bus.grant_dm},    32'h0);
        step();
        bus.mem_valid = 0;
        step();
        check("rstmid no pulse", n_if_v - if0, 0);

        // Conflict alternation, zero-wait memory responding to every request
        if0 = n_if_v; dm0 = n_dm_v; g0 = grant_log.size();
        bus.if_request = 1; bus.if_address = 8'h40;
        bus.dm_request = 1; bus.dm_we_re = 0; bus.dm_mask = 4'hF; bus.dm_address = 8'h30;
        bus.mem_data_out = 32'h0BADCAFE;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 7) begin
                bus.if_request = 0; bus.dm_request = 0;
            end
            bus.mem_valid = bus.mem_request;
        end
        step();
        bus.mem_valid = 0;
        step();
        check("alt if valids", n_if_v - if0, 2);
        check("alt dm valids", n_dm_v - dm0, 2);
        check("alt grants", grant_log.size() - g0, 4);
        if (grant_log.size() >= g0 + 4) begin
            check("alt grant0 dm", {31'b0, grant_log[g0]},   32'h1);
            check("alt grant1 if", {31'b0, grant_log[g0+1]}, 32'h0);
            check("alt grant2 dm", {31'b0, grant_log[g0+2]}, 32'h1);
            check("alt grant3 if", {31'b0, grant_log[g0+3]}, 32'h0);
        end
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
